rocket_stage_sequencer: RTL and testbench

Multi-stage burn controller for the rocket-thrust datapath. It holds per-stage configuration (specific impulse, dry mass, propellant mass) and computes the pre-burn and post-burn mass for each stage in firing order. It issues each stage's operands to a shared, external delta-v unit over a req/ack handshake and accumulates total velocity. It reports the final burnout mass and status to the top level.

---
 rtl/rocket_stage_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_rocket_stage_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rocket_stage_sequencer.sv
// Multi-stage burn sequencer. It stores per-stage Isp, dry mass and propellant
// mass, builds the stacked vehicle mass, then walks the stages in firing order.
// For each stage it hands (Isp, m0, m1) to an external delta-v unit and adds the
// returned delta-v into a saturating 64-bit total.
//
// Delta-v handshake: dv_req is held high with dv_isp/dv_m0/dv_m1 stable until
// the cycle in which dv_ack is high. That cycle is the transfer, and dv_result
// is sampled in it. dv_req is low in the following cycle. dv_req never
// rises again for the same stage. It drops without a transfer on abort or on
// timeout, and an ack in the abort cycle is discarded.
module rocket_stage_sequencer #(
    parameter int MAX_STAGES = 4,
    parameter int W          = 32,
    parameter int TIMEOUT    = 255,
    localparam int IDX_W     = (MAX_STAGES > 1) ? $clog2(MAX_STAGES) : 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [W-1:0]     cfg_isp,
    input  logic [W-1:0]     cfg_dry,
    input  logic [W-1:0]     cfg_prop,
    input  logic [W-1:0]     payload,
    input  logic [3:0]       num_stages,
    input  logic             start,
    input  logic             abort,
    output logic             dv_req,
    output logic [W-1:0]     dv_isp,
    output logic [W-1:0]     dv_m0,
    output logic [W-1:0]     dv_m1,
    input  logic             dv_ack,
    input  logic [63:0]      dv_result,
    output logic             busy,
    output logic [IDX_W-1:0] stage_idx,
    output logic             stage_done,
    output logic             done,
    output logic [63:0]      total_velocity,
    output logic [W-1:0]     burnout_mass,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [2:0]       dbg_state
);

    localparam int         MW     = W + 4;
    localparam int         TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [3:0] MAX_S4 = 4'(MAX_STAGES);

    localparam logic [2:0] E_NONE   = 3'd0;
    localparam logic [2:0] E_NSTAGE = 3'd1;
    localparam logic [2:0] E_MASS   = 3'd2;
    localparam logic [2:0] E_TMO    = 3'd3;
    localparam logic [2:0] E_OVF    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SUM   = 3'd1,
        S_REQ   = 3'd2,
        S_ACCUM = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            r_state;

    logic [W-1:0]      r_isp  [MAX_STAGES];
    logic [W-1:0]      r_dry  [MAX_STAGES];
    logic [W-1:0]      r_prop [MAX_STAGES];

    logic [MW-1:0]     r_msum;
    logic [3:0]        r_ns;
    logic [3:0]        r_j;
    logic [3:0]        r_k;
    logic [TW-1:0]     r_wait;
    logic [63:0]       r_result;

    logic              r_dv_req;
    logic [W-1:0]      r_dv_isp;
    logic [W-1:0]      r_dv_m0;
    logic [W-1:0]      r_dv_m1;
    logic              r_busy;
    logic [IDX_W-1:0]  r_stage_idx;
    logic              r_stage_done;
    logic              r_done;
    logic [63:0]       r_tv;
    logic [W-1:0]      r_burnout;
    logic              r_err;
    logic [2:0]        r_err_code;

    logic [IDX_W-1:0]  w_j_idx;
    logic [IDX_W-1:0]  w_k_idx;
    logic [3:0]        w_k_next;
    logic [IDX_W-1:0]  w_kn_idx;
    logic [MW-1:0]     w_msum_sum;
    logic [MW-1:0]     w_stage_mass;
    logic [MW-1:0]     w_msum_acc;
    logic [64:0]       w_tv_sum;
    logic [63:0]       w_tv_sat;
    logic              w_sum_ovf;
    logic              w_first_bad;
    logic              w_next_bad;
    logic              w_last_sum;
    logic              w_last_acc;
    logic              w_ns_bad;

    // Mass arithmetic and decision terms used by the sequencer
    always_comb begin
        w_j_idx      = r_j[IDX_W-1:0];
        w_k_idx      = r_k[IDX_W-1:0];
        w_k_next     = r_k + 4'd1;
        w_kn_idx     = w_k_next[IDX_W-1:0];
        w_msum_sum   = r_msum + MW'(r_dry[w_j_idx]) + MW'(r_prop[w_j_idx]);
        w_stage_mass = MW'(r_dry[w_k_idx]) + MW'(r_prop[w_k_idx]);
        w_msum_acc   = r_msum - w_stage_mass;
        w_tv_sum     = {1'b0, r_tv} + {1'b0, r_result};
        w_tv_sat     = w_tv_sum[64] ? {64{1'b1}} : w_tv_sum[63:0];
        // Stacked mass must fit the operand width before any request goes out
        w_sum_ovf    = |w_msum_sum[MW-1:W];
        // A stage whose propellant is not strictly less than m0 has no valid burn
        w_first_bad  = (w_msum_sum[W-1:0] == '0) ||
                       (r_prop[0] >= w_msum_sum[W-1:0]);
        w_next_bad   = (w_msum_acc[W-1:0] == '0) ||
                       (r_prop[w_kn_idx] >= w_msum_acc[W-1:0]);
        w_last_sum   = (r_j == r_ns - 4'd1);
        w_last_acc   = (w_k_next == r_ns);
        w_ns_bad     = (num_stages == 4'd0) || (num_stages > MAX_S4);
    end

    // Stage configuration table, frozen while a sequence is flying
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < MAX_STAGES; i++) begin
                r_isp[i]  <= '0;
                r_dry[i]  <= '0;
                r_prop[i] <= '0;
            end
        end else if (cfg_we && !r_busy) begin
            r_isp[cfg_idx]  <= cfg_isp;
            r_dry[cfg_idx]  <= cfg_dry;
            r_prop[cfg_idx] <= cfg_prop;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= S_IDLE;
            r_msum       <= '0;
            r_ns         <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_wait       <= '0;
            r_result     <= '0;
            r_dv_req     <= 1'b0;
            r_dv_isp     <= '0;
            r_dv_m0      <= '0;
            r_dv_m1      <= '0;
            r_busy       <= 1'b0;
            r_stage_idx  <= '0;
            r_stage_done <= 1'b0;
            r_done       <= 1'b0;
            r_tv         <= '0;
            r_burnout    <= '0;
            r_err        <= 1'b0;
            r_err_code   <= E_NONE;
        end else begin
            r_stage_done <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        if (w_ns_bad) begin
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= E_NSTAGE;
                        end else begin
                            r_state    <= S_SUM;
                            r_err      <= 1'b0;
                            r_err_code <= E_NONE;
                            r_tv       <= '0;
                            r_burnout  <= '0;
                            r_msum     <= MW'(payload);
                            r_j        <= '0;
                            r_ns       <= num_stages;
                            r_busy     <= 1'b1;
                        end
                    end else if (r_state == S_DONE) begin
                        r_state <= S_IDLE;
                    end
                end

                S_SUM: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_dv_req <= 1'b0;
                    end else begin
                        r_msum <= w_msum_sum;
                        if (w_last_sum) begin
                            r_k <= '0;
                            if (w_sum_ovf) begin
                                r_state    <= S_ERR;
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                                r_err_code <= E_OVF;
                            end else if (w_first_bad) begin
                                r_state    <= S_ERR;
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                                r_err_code <= E_MASS;
                            end else begin
                                r_state     <= S_REQ;
                                r_dv_req    <= 1'b1;
                                r_dv_m0     <= w_msum_sum[W-1:0];
                                r_dv_m1     <= w_msum_sum[W-1:0] - r_prop[0];
                                r_dv_isp    <= r_isp[0];
                                r_stage_idx <= '0;
                                r_wait      <= '0;
                            end
                        end else begin
                            r_j <= r_j + 4'd1;
                        end
                    end
                end

                S_REQ: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_dv_req <= 1'b0;
                    end else if (dv_ack) begin
                        r_result     <= dv_result;
                        r_dv_req     <= 1'b0;
                        r_stage_done <= 1'b1;
                        r_state      <= S_ACCUM;
                    end else if (r_wait == TW'(TIMEOUT - 1)) begin
                        r_dv_req   <= 1'b0;
                        r_state    <= S_ERR;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= E_TMO;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end

                S_ACCUM: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_dv_req <= 1'b0;
                    end else begin
                        r_tv   <= w_tv_sat;
                        r_msum <= w_msum_acc;
                        r_k    <= w_k_next;
                        if (w_last_acc) begin
                            // Burnout leaves payload plus the last stage's dry mass
                            r_burnout <= r_msum[W-1:0] - r_prop[w_k_idx];
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                        end else if (w_next_bad) begin
                            r_state    <= S_ERR;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= E_MASS;
                        end else begin
                            r_state     <= S_REQ;
                            r_dv_req    <= 1'b1;
                            r_dv_m0     <= w_msum_acc[W-1:0];
                            r_dv_m1     <= w_msum_acc[W-1:0] - r_prop[w_kn_idx];
                            r_dv_isp    <= r_isp[w_kn_idx];
                            r_stage_idx <= w_kn_idx;
                            r_wait      <= '0;
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_dv_req <= 1'b0;
                end
            endcase
        end
    end

    assign dv_req         = r_dv_req;
    assign dv_isp         = r_dv_isp;
    assign dv_m0          = r_dv_m0;
    assign dv_m1          = r_dv_m1;
    assign busy           = r_busy;
    assign stage_idx      = r_stage_idx;
    assign stage_done     = r_stage_done;
    assign done           = r_done;
    assign total_velocity = r_tv;
    assign burnout_mass   = r_burnout;
    assign err            = r_err;
    assign err_code       = r_err_code;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_rocket_stage_sequencer.sv
// Directed bench for rocket_stage_sequencer. A default-parameter instance
// carries the functional checks; a TIMEOUT=8 instance shares its inputs so
// the timeout path can be exercised with a short wait.
module tb_rocket_stage_sequencer;
  localparam int W = 32;
  localparam int IDX_W = 2;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [W-1:0]     cfg_isp, cfg_dry, cfg_prop, payload;
  logic [3:0]       num_stages;
  logic             start, abort, dv_ack;
  logic [63:0]      dv_result;

  logic             dv_req, busy, stage_done, done, err;
  logic [W-1:0]     dv_isp, dv_m0, dv_m1, burnout_mass;
  logic [IDX_W-1:0] stage_idx;
  logic [63:0]      total_velocity;
  logic [2:0]       err_code, dbg_state;

  logic             dv_req_b, busy_b, stage_done_b, done_b, err_b;
  logic [W-1:0]     dv_isp_b, dv_m0_b, dv_m1_b, burnout_mass_b;
  logic [IDX_W-1:0] stage_idx_b;
  logic [63:0]      total_velocity_b;
  logic [2:0]       err_code_b, dbg_state_b;

  int checks = 0;
  int errors = 0;

  rocket_stage_sequencer u_dut (
    .clk(clk), .resetb(resetb), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_isp(cfg_isp), .cfg_dry(cfg_dry), .cfg_prop(cfg_prop),
    .payload(payload), .num_stages(num_stages), .start(start), .abort(abort),
    .dv_req(dv_req), .dv_isp(dv_isp), .dv_m0(dv_m0), .dv_m1(dv_m1),
    .dv_ack(dv_ack), .dv_result(dv_result), .busy(busy), .stage_idx(stage_idx),
    .stage_done(stage_done), .done(done), .total_velocity(total_velocity),
    .burnout_mass(burnout_mass), .err(err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  rocket_stage_sequencer #(.TIMEOUT(8)) u_dut_to (
    .clk(clk), .resetb(resetb), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_isp(cfg_isp), .cfg_dry(cfg_dry), .cfg_prop(cfg_prop),
    .payload(payload), .num_stages(num_stages), .start(start), .abort(abort),
    .dv_req(dv_req_b), .dv_isp(dv_isp_b), .dv_m0(dv_m0_b), .dv_m1(dv_m1_b),
    .dv_ack(dv_ack), .dv_result(dv_result), .busy(busy_b),
    .stage_idx(stage_idx_b), .stage_done(stage_done_b), .done(done_b),
    .total_velocity(total_velocity_b), .burnout_mass(burnout_mass_b),
    .err(err_b), .err_code(err_code_b), .dbg_state(dbg_state_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_cfg(input logic [IDX_W-1:0] idx, input logic [W-1:0] isp,
                           input logic [W-1:0] dry, input logic [W-1:0] prop);
    cfg_we = 1'b1; cfg_idx = idx; cfg_isp = isp; cfg_dry = dry; cfg_prop = prop;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic fire(input logic [3:0] ns, input logic [W-1:0] pl);
    num_stages = ns; payload = pl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for a request, checks its operands, holds off the ack for 'delay'
  // cycles while checking stability, then acks (optionally with abort).
  task automatic serve(input string tag, input logic [W-1:0] m0, input logic [W-1:0] m1,
                       input logic [W-1:0] isp, input logic [IDX_W-1:0] idx,
                       input int delay, input logic [63:0] res, input bit do_abort);
    int n = 0;
    while (dv_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_req"}, dv_req, 1);
    check({tag, "_m0"}, dv_m0, m0);
    check({tag, "_m1"}, dv_m1, m1);
    check({tag, "_isp"}, dv_isp, isp);
    check({tag, "_idx"}, stage_idx, idx);
    for (int d = 0; d < delay; d++) begin
      tick();
      check({tag, "_hold_req"}, dv_req, 1);
      check({tag, "_hold_ops"}, {dv_m0, dv_m1}, {m0, m1});
    end
    dv_ack = 1'b1; dv_result = res; abort = do_abort;
    tick();
    dv_ack = 1'b0; abort = 1'b0;
    check({tag, "_stage_done"}, stage_done, !do_abort);
    check({tag, "_req_low"}, dv_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int seen_done;
    resetb = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_isp = '0; cfg_dry = '0;
    cfg_prop = '0; payload = '0; num_stages = '0; start = 1'b0; abort = 1'b0;
    dv_ack = 1'b0; dv_result = '0;
    repeat (3) tick();

    // Reset state
    check("rst_req", dv_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code}, 0);
    check("rst_tv", total_velocity, 0);
    check("rst_burnout", burnout_mass, 0);
    check("rst_state", dbg_state, 0);
    resetb = 1'b1;
    tick();

    // Single stage: 1000 -> 300, done in cycle 4 after start
    write_cfg(0, 300, 200, 700);
    fire(1, 100);
    check("s1_c1_busy", busy, 1);
    check("s1_c1_req", dv_req, 0);
    tick();
    check("s1_c2_req", dv_req, 1);
    check("s1_m0", dv_m0, 1000);
    check("s1_m1", dv_m1, 300);
    check("s1_isp", dv_isp, 300);
    dv_ack = 1'b1; dv_result = 64'd700;
    tick();
    dv_ack = 1'b0;
    check("s1_c3_stage_done", stage_done, 1);
    check("s1_c3_done", done, 0);
    tick();
    check("s1_c4_done", done, 1);
    check("s1_c4_busy", busy, 0);
    check("s1_tv", total_velocity, 700);
    check("s1_burnout", burnout_mass, 300);
    tick();
    check("s1_c5_done", done, 0);
    check("s1_c5_state", dbg_state, 0);

    // Two stages, with a config write attempted while busy
    write_cfg(0, 250, 300, 600);
    write_cfg(1, 350, 100, 400);
    fire(2, 100);
    write_cfg(1, 9, 9, 9);
    serve("t2s0", 1500, 900, 250, 0, 0, 600, 0);
    serve("t2s1", 600, 200, 350, 1, 0, 400, 0);
    tick();
    check("t2_done", done, 1);
    check("t2_tv", total_velocity, 1000);
    check("t2_burnout", burnout_mass, 200);

    // Ack backpressure of 10 cycles on each stage
    fire(2, 100);
    serve("bp0", 1500, 900, 250, 0, 10, 600, 0);
    serve("bp1", 600, 200, 350, 1, 10, 400, 0);
    tick();
    check("bp_done", done, 1);
    check("bp_tv", total_velocity, 1000);
    check("bp_burnout", burnout_mass, 200);

    // Bad num_stages
    fire(0, 100);
    check("ns0_err", {err, err_code}, {1'b1, 3'd1});
    check("ns0_busy", busy, 0);
    fire(5, 100);
    check("ns5_err", {err, err_code}, {1'b1, 3'd1});
    check("ns5_state", dbg_state, 5);

    // Propellant equal to stacked mass
    write_cfg(0, 300, 0, 1000);
    fire(1, 0);
    check("mass_c1_req", dv_req, 0);
    tick();
    check("mass_err", {err, err_code}, {1'b1, 3'd2});
    check("mass_c2_req", dv_req, 0);

    // Stacked mass overflow
    write_cfg(0, 300, 1, 1);
    fire(1, 32'hFFFF_FFFF);
    tick();
    check("ovf_err", {err, err_code}, {1'b1, 3'd4});

    // Timeout on the TIMEOUT=8 instance, then recovery
    write_cfg(0, 300, 200, 700);
    fire(1, 100);
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dv_req_b === 1'b1) hi++;
    end
    check("to_req_cycles", hi, 8);
    check("to_err", {err_b, err_code_b}, {1'b1, 3'd3});
    check("to_busy", busy_b, 0);
    check("to_req_low", dv_req_b, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("to_abort_a", busy, 0);
    check("to_abort_ignored_b", {err_b, err_code_b}, {1'b1, 3'd3});
    fire(1, 100);
    check("rec_err_clear", err_b, 0);
    check("rec_busy", busy_b, 1);
    serve("rec", 1000, 300, 300, 0, 0, 700, 0);
    tick();
    check("rec_done_b", done_b, 1);
    check("rec_done_a", done, 1);
    check("rec_tv_b", total_velocity_b, 700);

    // Abort together with the ack of stage 1
    write_cfg(0, 250, 300, 600);
    fire(2, 100);
    serve("ab0", 1500, 900, 250, 0, 0, 600, 0);
    serve("ab1", 600, 200, 350, 1, 0, 400, 1);
    check("ab_busy", busy, 0);
    check("ab_state", dbg_state, 0);
    seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1 || stage_done === 1'b1) seen_done++;
      tick();
    end
    check("ab_no_done", seen_done, 0);
    check("ab_tv", total_velocity, 600);

    // Saturating total velocity
    fire(2, 100);
    serve("sat0", 1500, 900, 250, 0, 0, 64'h8000_0000_0000_0000, 0);
    serve("sat1", 600, 200, 350, 1, 0, 64'h8000_0000_0000_0000, 0);
    tick();
    check("sat_done", done, 1);
    check("sat_tv", total_velocity, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
